// File: rtl/sgemm_mul_arb.sv
// Two-requester round-robin front end for a shared LATENCY-stage pipelined multiplier.
// A tag shift register moving in lockstep with the multiplier tracks which requester owns each product.
`timescale 1ns/1ps
module sgemm_mul_arb #(
    parameter int DIN0_WIDTH = 63,
    parameter int DIN1_WIDTH = 8,
    parameter int DOUT_WIDTH = 63,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [DIN0_WIDTH-1:0] req_a0,
    input  logic [DIN0_WIDTH-1:0] req_a1,
    input  logic [DIN1_WIDTH-1:0] req_b0,
    input  logic [DIN1_WIDTH-1:0] req_b1,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_id,
    output logic [DOUT_WIDTH-1:0] res_data,
    output logic                  mul_ce,
    output logic [DIN0_WIDTH-1:0] mul_din0,
    output logic [DIN1_WIDTH-1:0] mul_din1,
    input  logic [DOUT_WIDTH-1:0] mul_dout
);

    // Handshake: a request transfers when req_valid[i] & req_ready[i]; a product
    // leaves when res_valid & res_ready. Issue and pop may share one cycle.

    logic [LATENCY-1:0] tag_valid_q, tag_valid_d;
    logic [LATENCY-1:0] tag_id_q, tag_id_d;
    logic               ptr_q, ptr_d;
    logic [1:0]         grant;

    always_comb begin
        mul_ce    = ~tag_valid_q[LATENCY-1] | res_ready;
        grant     = 2'b00;
        ptr_d     = ptr_q;
        tag_valid_d = tag_valid_q;
        tag_id_d    = tag_id_q;

        // Grant only from the request valids, the pointer and the enable.
        if (mul_ce && reset) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end

        if (grant[0]) begin
            ptr_d = 1'b1;
        end else if (grant[1]) begin
            ptr_d = 1'b0;
        end

        if (mul_ce) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                tag_valid_d[i] = tag_valid_q[i-1];
                tag_id_d[i]    = tag_id_q[i-1];
            end
            tag_valid_d[0] = |grant;
            tag_id_d[0]    = grant[1];
        end

        req_ready = grant;
        mul_din0  = grant[1] ? req_a1 : req_a0;
        mul_din1  = grant[1] ? req_b1 : req_b0;
        res_valid = tag_valid_q[LATENCY-1];
        res_id    = tag_id_q[LATENCY-1];
        res_data  = mul_dout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid_q <= '0;
            tag_id_q    <= '0;
            ptr_q       <= 1'b0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
            ptr_q       <= ptr_d;
        end
    end

endmodule

// File: tb/tb_sgemm_mul_arb.sv
// Bench for sgemm_mul_arb: behavioural multiplier, queue-of-ages reference model,
// table of arithmetic vectors, directed corner sequences and a random phase.
`timescale 1ns/1ps
module tb_sgemm_mul_arb;

    localparam int W0  = 63;
    localparam int W1  = 8;
    localparam int WD  = 63;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [W0-1:0] req_a0, req_a1;
    logic [W1-1:0] req_b0, req_b1;
    logic          res_valid;
    logic          res_ready;
    logic          res_id;
    logic [WD-1:0] res_data;
    logic          mul_ce;
    logic [W0-1:0] mul_din0;
    logic [W1-1:0] mul_din1;
    logic [WD-1:0] mul_dout;

    always #5 clk = ~clk;

    sgemm_mul_arb #(
        .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WD), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout)
    );

    // Signed A times unsigned B, truncated to WD bits.
    function automatic logic [WD-1:0] mul_f(input logic [W0-1:0] a, input logic [W1-1:0] b);
        logic signed [W0+W1:0] p;
        p = $signed({{(W1+1){a[W0-1]}}, a}) * $signed({{(W0+1){1'b0}}, b});
        return p[WD-1:0];
    endfunction

    // Shared multiplier: LAT stages, moves only when enabled, never reset.
    logic [WD-1:0] mpipe [LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            for (int i = LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
            mpipe[0] <= mul_f(mul_din0, mul_din1);
        end
    end
    assign mul_dout = mpipe[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight ops kept in issue order; an op reaches the
    // output after LAT enabled cycles counted from its issue edge.
    int            age_q[$];
    logic [WD-1:0] exp_q[$];
    logic          id_q[$];
    logic          mdl_prio;
    logic          exp_ce;
    logic          exp_rv;
    logic [1:0]    exp_grant;

    task automatic model_clear();
        age_q.delete();
        exp_q.delete();
        id_q.delete();
        mdl_prio = 1'b0;
    endtask

    task automatic model_check();
        if (!reset) model_clear();
        exp_rv = (age_q.size() > 0) && (age_q[0] == LAT);
        exp_ce = !exp_rv || res_ready;
        exp_grant = 2'b00;
        if (reset && exp_ce) begin
            if (req_valid == 2'b11) exp_grant = mdl_prio ? 2'b10 : 2'b01;
            else exp_grant = req_valid;
        end
        chk("res_valid", {63'd0, res_valid}, {63'd0, exp_rv});
        chk("mul_ce", {63'd0, mul_ce}, {63'd0, exp_ce});
        chk("req_ready", {62'd0, req_ready}, {62'd0, exp_grant});
        if (exp_rv && res_valid) begin
            chk("res_id", {63'd0, res_id}, {63'd0, id_q[0]});
            chk("res_data", {1'b0, res_data}, {1'b0, exp_q[0]});
        end
        if (exp_grant == 2'b10) begin
            chk("mul_din0", {1'b0, mul_din0}, {1'b0, req_a1});
            chk("mul_din1", {56'd0, mul_din1}, {56'd0, req_b1});
        end else begin
            chk("mul_din0", {1'b0, mul_din0}, {1'b0, req_a0});
            chk("mul_din1", {56'd0, mul_din1}, {56'd0, req_b0});
        end
    endtask

    task automatic model_update();
        if (!reset) begin
            model_clear();
        end else if (exp_ce) begin
            if (exp_rv) begin
                void'(age_q.pop_front());
                void'(exp_q.pop_front());
                void'(id_q.pop_front());
            end
            foreach (age_q[i]) age_q[i]++;
            if (exp_grant == 2'b01) begin
                age_q.push_back(1);
                exp_q.push_back(mul_f(req_a0, req_b0));
                id_q.push_back(1'b0);
                mdl_prio = 1'b1;
            end else if (exp_grant == 2'b10) begin
                age_q.push_back(1);
                exp_q.push_back(mul_f(req_a1, req_b1));
                id_q.push_back(1'b1);
                mdl_prio = 1'b0;
            end
        end
    endtask

    // One clock: model absorbs the edge, inputs change on the falling edge, checks 1ns later.
    task automatic cyc(input logic rst, input logic [1:0] v, input logic rr,
                       input logic [W0-1:0] a0, input logic [W1-1:0] b0,
                       input logic [W0-1:0] a1, input logic [W1-1:0] b1);
        @(posedge clk);
        model_update();
        @(negedge clk);
        reset     = rst;
        req_valid = v;
        res_ready = rr;
        req_a0 = a0; req_b0 = b0;
        req_a1 = a1; req_b1 = b1;
        #1;
        model_check();
    endtask

    function automatic logic [W0-1:0] rnd_a();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W0-1:0];
    endfunction

    task automatic rcyc(input logic rst, input logic [1:0] v, input logic rr);
        cyc(rst, v, rr, rnd_a(), W1'($urandom_range(0, 255)), rnd_a(), W1'($urandom_range(0, 255)));
    endtask

    typedef struct {
        logic          id;
        logic [W0-1:0] a;
        logic [W1-1:0] b;
        logic [WD-1:0] exp_p;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic       found;
        logic [1:0] prev_g;

        vecs[0] = '{1'b0, 63'h7FFF_FFFF_FFFF_FFFD, 8'd5,   63'h7FFF_FFFF_FFFF_FFF1};
        vecs[1] = '{1'b1, 63'h4000_0000_0000_0000, 8'd255, 63'h4000_0000_0000_0000};
        vecs[2] = '{1'b0, 63'h4000_0000_0000_0000, 8'd1,   63'h4000_0000_0000_0000};
        vecs[3] = '{1'b1, 63'h7FFF_FFFF_FFFF_FFFF, 8'd255, 63'h7FFF_FFFF_FFFF_FF01};
        vecs[4] = '{1'b0, 63'h3FFF_FFFF_FFFF_FFFF, 8'd2,   63'h7FFF_FFFF_FFFF_FFFE};
        vecs[5] = '{1'b1, 63'd12345,               8'd0,   63'd0};
        vecs[6] = '{1'b0, 63'd1000,                8'd200, 63'd200000};

        reset = 1'b0; req_valid = 2'b00; res_ready = 1'b0;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        model_clear();
        exp_ce = 1'b1; exp_rv = 1'b0; exp_grant = 2'b00;

        // Held in reset with both requesting: no grants, pipeline enabled.
        for (int i = 0; i < 3; i++) rcyc(1'b0, 2'b11, 1'b0);

        // Lone requester 1 with pointer at 0 after reset.
        rcyc(1'b1, 2'b10, 1'b1);
        chk("lone_req1_grant", {62'd0, req_ready}, 64'd2);
        for (int i = 0; i < 6; i++) rcyc(1'b1, 2'b00, 1'b1);

        // Arithmetic table, one isolated op at a time.
        foreach (vecs[k]) begin
            if (vecs[k].id) cyc(1'b1, 2'b10, 1'b1, rnd_a(), 8'd7, vecs[k].a, vecs[k].b);
            else            cyc(1'b1, 2'b01, 1'b1, vecs[k].a, vecs[k].b, rnd_a(), 8'd9);
            found = 1'b0;
            for (int t = 0; t < 20 && !found; t++) begin
                rcyc(1'b1, 2'b00, 1'b1);
                if (res_valid) begin
                    found = 1'b1;
                    chk("vec_data", {1'b0, res_data}, {1'b0, vecs[k].exp_p});
                    chk("vec_id", {63'd0, res_id}, {63'd0, vecs[k].id});
                end
            end
            if (!found) chk("vec_timeout", 64'd0, 64'd1);
        end

        // Contention: grants must alternate every cycle.
        rcyc(1'b1, 2'b11, 1'b1);
        prev_g = req_ready;
        for (int i = 0; i < 8; i++) begin
            rcyc(1'b1, 2'b11, 1'b1);
            chk("contention_alt", {62'd0, req_ready}, {62'd0, ~prev_g});
            prev_g = req_ready;
        end
        for (int i = 0; i < 6; i++) rcyc(1'b1, 2'b00, 1'b1);

        // Backpressure: three ops, consumer stalled, then release.
        rcyc(1'b1, 2'b01, 1'b0);
        rcyc(1'b1, 2'b10, 1'b0);
        rcyc(1'b1, 2'b01, 1'b0);
        rcyc(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rcyc(1'b1, 2'b11, 1'b0);
            chk("stall_ce", {63'd0, mul_ce}, 64'd0);
            chk("stall_ready", {62'd0, req_ready}, 64'd0);
            chk("stall_depth", 64'(exp_q.size()), 64'd3);
        end
        for (int i = 0; i < 8; i++) rcyc(1'b1, 2'b00, 1'b1);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset with two ops in flight: results discarded.
        rcyc(1'b1, 2'b01, 1'b1);
        rcyc(1'b1, 2'b10, 1'b1);
        rcyc(1'b0, 2'b11, 1'b1);
        chk("midreset_rv", {63'd0, res_valid}, 64'd0);
        rcyc(1'b0, 2'b11, 1'b1);
        for (int i = 0; i < 8; i++) rcyc(1'b1, 2'b00, 1'b1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            rcyc(1'b1, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7));
        for (int i = 0; i < 12; i++) rcyc(1'b1, 2'b00, 1'b1);
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sgemm_mul_arb.md
SGEMM_MUL_ARB -- requirements
Module: sgemm_mul_arb

Interface
REQ-001 Parameter DIN0_WIDTH, default 63, signed multiplicand width.
REQ-002 Parameter DIN1_WIDTH, default 8, unsigned multiplier width.
REQ-003 Parameter DOUT_WIDTH, default 63, product width (truncated to DOUT_WIDTH LSBs).
REQ-004 Parameter LATENCY, default 4, multiplier ce-enabled cycles from operand capture to dout.
REQ-005 Port clk  in  1  sole clock, rising edge.
REQ-006 Port reset  in  1  asynchronous, active-low reset.
REQ-007 Port req_valid  in  2  per-requester operand valid (bit i = requester i).
REQ-008 Port req_ready  out  2  per-requester grant; transfer when req_valid[i] & req_ready[i].
REQ-009 Port req_a0, req_a1  in  DIN0_WIDTH each  signed operand per requester.
REQ-010 Port req_b0, req_b1  in  DIN1_WIDTH each  unsigned operand per requester.
REQ-011 Port res_valid  out  1  product available.
REQ-012 Port res_ready  in  1  consumer accepts product.
REQ-013 Port res_id  out  1  index of requester that issued the product.
REQ-014 Port res_data  out  DOUT_WIDTH  product.
REQ-015 Port mul_ce  out  1  clock enable to shared multiplier.
REQ-016 Port mul_din0  out  DIN0_WIDTH  operand A to multiplier.
REQ-017 Port mul_din1  out  DIN1_WIDTH  operand B to multiplier.
REQ-018 Port mul_dout  in  DOUT_WIDTH  multiplier result, LATENCY ce-cycles after issue.

Function
REQ-019 Block shall share one LATENCY-stage pipelined multiplier between two requesters, tracking a valid bit and 1-bit id per stage in a LATENCY-deep tag shift register.
REQ-020 Tag register shall advance only in cycles where mul_ce=1, exactly mirroring multiplier stage movement.
REQ-021 mul_ce shall equal (!tag_valid[LATENCY-1]) | res_ready; pipeline stalls only when output holds an unaccepted product.
REQ-022 res_valid shall equal tag_valid[LATENCY-1]; res_id shall equal tag_id[LATENCY-1]; res_data shall equal mul_dout.
REQ-023 res_valid/res_id/res_data shall hold stable while res_valid=1 and res_ready=0.
REQ-024 Arbitration: when mul_ce=1, at most one req_ready bit shall assert, chosen round-robin among valid requesters; when mul_ce=0, req_ready=2'b00.
REQ-025 Round-robin pointer shall point at requester with priority; after a grant to i, priority shall move to 1-i; with no grant pointer shall hold.
REQ-026 Only one requester valid: it shall be granted regardless of pointer (no bubble insertion).
REQ-027 req_ready shall depend combinationally on req_valid, pointer and mul_ce only, never on req_a*/req_b*.
REQ-028 mul_din0/mul_din1 shall mux the granted requester's operands; with no grant they shall carry requester 0 operands and the issued tag bit shall be 0.
REQ-029 Tag stage 0 shall load valid=|grant, id=granted index on each mul_ce cycle.
REQ-030 Simultaneous pop (res_valid&res_ready) and new issue shall both occur in one cycle; sustained throughput shall be one product per clock.
REQ-031 Products shall exit in issue order; no reordering, no drop, no duplication.

Reset
REQ-032 On reset low, all tag valid bits, tag ids and pointer shall clear asynchronously (pointer=requester 0).
REQ-033 During and after reset: res_valid=0, req_ready=00 while reset low, mul_ce=1 (pipeline flushes garbage).
REQ-034 Products in flight when reset asserts shall be discarded; first grant occurs on first clk edge with reset high.

Verification
REQ-035 Single op: req0 a=-3, b=5 one cycle, res_ready=1 -> res_valid after 4 cycles, res_data=-15, res_id=0.
REQ-036 Contention: both valid every cycle, res_ready=1 -> grants alternate 0,1,0,1; results in same id order, 1/clk.
REQ-037 Backpressure: 3 ops issued, res_ready=0 -> res_valid held with first product, mul_ce=0, req_ready=00; release -> 3 products in order, none lost.
REQ-038 Boundary: a=most-negative DIN0_WIDTH value, b=255 -> res_data = low DOUT_WIDTH bits of exact product.
REQ-039 Reset mid-flight: reset low with 2 ops in pipe -> res_valid=0 immediately, no stale result after release.
REQ-040 Lone requester 1 valid with pointer at 0 -> granted same cycle, res_id=1.
